multiword_add_ctrl: RTL and testbench

MULTIWORD_ADD_CTRL -- requirements
Module: multiword_add_ctrl

---
 rtl/multiword_add_ctrl.sv | 89 ++++++++
 tb/tb_multiword_add_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/multiword_add_ctrl.sv
// multiword_add_ctrl: nibble-serial W-bit adder sequencer for an external 4-bit adder.
// Define MULTIWORD_ADD_OVF_EN to add the two's-complement overflow output ovf.
module multiword_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  input  logic                 cin_in,
  output logic [3:0]           fa_a,
  output logic [3:0]           fa_b,
  output logic                 fa_cin,
  input  logic [3:0]           fa_sum,
  input  logic                 fa_cout,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout_out
`ifdef MULTIWORD_ADD_OVF_EN
  ,
  output logic                 ovf
`endif
);
  localparam int W = 4*NIBBLES;
  localparam int CW = $clog2(NIBBLES+1);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES-1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [W-1:0] a_r, b_r, stage, stage_next;
  logic [W+3:0] cat;
  logic carry;
  logic [CW-1:0] cnt;
`ifdef MULTIWORD_ADD_OVF_EN
  logic a_msb, b_msb;
`endif
  // operands shift right so the active nibble is always at [3:0]; sums shift in from the top
  assign cat = {fa_sum, stage};
  assign stage_next = cat[W+3:4];
  assign busy = state == RUN;
  assign done = state == DONE;
  assign fa_a = busy ? a_r[3:0] : 4'd0;
  assign fa_b = busy ? b_r[3:0] : 4'd0;
  assign fa_cin = busy & carry;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      stage <= '0;
      carry <= 1'b0;
      cnt <= '0;
      result <= '0;
      cout_out <= 1'b0;
`ifdef MULTIWORD_ADD_OVF_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      ovf <= 1'b0;
`endif
    end else if (state == RUN) begin
      a_r <= a_r >> 4;
      b_r <= b_r >> 4;
      stage <= stage_next;
      carry <= fa_cout;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        result <= stage_next;
        cout_out <= fa_cout;
        state <= DONE;
`ifdef MULTIWORD_ADD_OVF_EN
        ovf <= (a_msb == b_msb) && (fa_sum[3] != a_msb);
`endif
      end
    end else if (start) begin
      state <= RUN;
      a_r <= op_a;
      b_r <= op_b;
      carry <= cin_in;
      cnt <= '0;
`ifdef MULTIWORD_ADD_OVF_EN
      a_msb <= op_a[W-1];
      b_msb <= op_b[W-1];
`endif
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_multiword_add_ctrl.sv
// tb_multiword_add_ctrl: scoreboard bench with a behavioural 4-bit adder and full-width reference sums.
module tb_multiword_add_ctrl;
  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic [15:0] op_a = 0, op_b = 0;
  logic cin_in = 0;
  logic [3:0] fa_a, fa_b, fa_sum;
  logic fa_cin, fa_cout, busy, done, cout_out;
  logic [15:0] result;
`ifdef MULTIWORD_ADD_OVF_EN
  logic ovf;
`endif
  int checks = 0, errors = 0, busy_cnt = 0;
  logic [17:0] sb[$];

  multiword_add_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .cin_in(cin_in),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_sum(fa_sum), .fa_cout(fa_cout),
    .busy(busy), .done(done), .result(result), .cout_out(cout_out)
`ifdef MULTIWORD_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );

  assign {fa_cout, fa_sum} = 5'(fa_a) + 5'(fa_b) + 5'(fa_cin);
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // issues one accepted op from IDLE/DONE; returns during the DONE cycle
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c, input bit garbage);
    logic [16:0] s;
    start = 1;
    op_a = a;
    op_b = b;
    cin_in = c;
    step(1);
    s = {1'b0, a} + {1'b0, b} + 17'(c);
    sb.push_back({(a[15] == b[15]) && (s[15] != a[15]), s});
    start = 0;
    repeat (4) begin
      if (garbage) begin
        start = 1'($urandom);
        op_a = 16'($urandom);
        op_b = 16'($urandom);
        cin_in = 1'($urandom);
      end
      step(1);
    end
    start = 0;
  endtask

  always @(negedge clk) begin
    logic [17:0] e;
    if (rst) busy_cnt = 0;
    else begin
      if (busy) busy_cnt++;
      else chk("fa_idle", {23'd0, fa_a, fa_b, fa_cin}, 0);
      if (done) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = sb.pop_front();
          chk("result", {16'd0, result}, {16'd0, e[15:0]});
          chk("cout_out", {31'd0, cout_out}, {31'd0, e[16]});
`ifdef MULTIWORD_ADD_OVF_EN
          chk("ovf", {31'd0, ovf}, {31'd0, e[17]});
`endif
          chk("latency", busy_cnt, 4);
        end
        busy_cnt = 0;
      end
    end
  end

  initial begin
    start = 1;
    op_a = 16'h1111;
    op_b = 16'h2222;
    step(2);
    rst = 0;
    start = 0;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_result", {16'd0, result}, 0);
    chk("rst_cout", {31'd0, cout_out}, 0);
    do_op(16'h1234, 16'h4321, 0, 0);
    step(2);
    do_op(16'hFFFF, 16'h0000, 1, 0);
    do_op(16'h7FFF, 16'h0001, 0, 0);
    step(1);
    start = 1;
    op_a = 16'hAAAA;
    op_b = 16'h5555;
    cin_in = 0;
    step(1);
    start = 0;
    step(1);
    rst = 1;
    step(1);
    rst = 0;
    chk("mid_rst_busy", {31'd0, busy}, 0);
    chk("mid_rst_done", {31'd0, done}, 0);
    chk("mid_rst_result", {16'd0, result}, 0);
    chk("mid_rst_cout", {31'd0, cout_out}, 0);
    chk("mid_rst_fa", {23'd0, fa_a, fa_b, fa_cin}, 0);
`ifdef MULTIWORD_ADD_OVF_EN
    chk("mid_rst_ovf", {31'd0, ovf}, 0);
`endif
    step(6);
    do_op(16'h0F0F, 16'h1234, 0, 1);
    do_op(16'h0001, 16'h0001, 0, 0);
    step(1);
    repeat (40) begin
      do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(1, 0) == 1) step($urandom_range(2, 1));
    end
    step(1);
    repeat (20) if (sb.size() != 0) step(1);
    chk("drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
